// File: rtl/udp_tx_pkg.sv
// Shared types for the UDP TX header arbiter: requester header fields, full
// outgoing header, FSM state encoding and the header assembly helper.
package udp_tx_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } udp_tx_state_t;

    typedef struct packed {
        logic [47:0] eth_dest_mac;
        logic [5:0]  ip_dscp;
        logic [1:0]  ip_ecn;
        logic [7:0]  ip_ttl;
        logic [31:0] ip_dest_ip;
        logic [15:0] udp_source_port;
        logic [15:0] udp_dest_port;
        logic [15:0] udp_length;
        logic [15:0] udp_checksum;
    } udp_tx_req_t;

    typedef struct packed {
        logic [47:0] eth_dest_mac;
        logic [47:0] eth_src_mac;
        logic [15:0] eth_type;
        logic [5:0]  ip_dscp;
        logic [1:0]  ip_ecn;
        logic [7:0]  ip_ttl;
        logic [31:0] ip_source_ip;
        logic [31:0] ip_dest_ip;
        logic [15:0] udp_source_port;
        logic [15:0] udp_dest_port;
        logic [15:0] udp_length;
        logic [15:0] udp_checksum;
    } udp_tx_hdr_t;

    // Local source fields and the IPv4 ethertype always override the requester.
    function automatic udp_tx_hdr_t build_hdr(input udp_tx_req_t req,
                                              input logic [47:0] mac,
                                              input logic [31:0] ip);
        udp_tx_hdr_t h;
        h.eth_dest_mac    = req.eth_dest_mac;
        h.eth_src_mac     = mac;
        h.eth_type        = ETH_TYPE_IPV4;
        h.ip_dscp         = req.ip_dscp;
        h.ip_ecn          = req.ip_ecn;
        h.ip_ttl          = req.ip_ttl;
        h.ip_source_ip    = ip;
        h.ip_dest_ip      = req.ip_dest_ip;
        h.udp_source_port = req.udp_source_port;
        h.udp_dest_port   = req.udp_dest_port;
        h.udp_length      = req.udp_length;
        h.udp_checksum    = req.udp_checksum;
        return h;
    endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_grant_idx,
    output logic               o_any_valid
);

    int w_cand;

    // Rotating priority search starting at the pointer.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_valid = 1'b0;
        w_cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = (int'(i_rr_ptr) + i) % NUM_REQ;
            if (!o_any_valid && i_req[w_cand]) begin
                o_any_valid     = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = IW'(w_cand);
            end else begin
                o_any_valid = o_any_valid;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Per-datagram round-robin arbiter in front of a UDP stack header/payload
// input; the grant spans one header handshake and every beat up to tlast.
module udp_tx_arbiter
    import udp_tx_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [47:0]                         cfg_local_mac,
    input  logic [31:0]                         cfg_local_ip,
    input  logic [NUM_REQ-1:0]                  req_hdr_valid,
    output logic [NUM_REQ-1:0]                  req_hdr_ready,
    input  udp_tx_req_t [NUM_REQ-1:0]           req_hdr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_tdata,
    input  logic [NUM_REQ-1:0]                  req_tvalid,
    output logic [NUM_REQ-1:0]                  req_tready,
    input  logic [NUM_REQ-1:0]                  req_tlast,
    output logic                                udp_hdr_valid,
    input  logic                                udp_hdr_ready,
    output udp_tx_hdr_t                         udp_hdr,
    output logic [DATA_WIDTH-1:0]               m_tdata,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic                                m_tlast,
    output logic [IW-1:0]                       grant_id,
    output logic                                busy
);

    udp_tx_state_t    r_state;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_grant_id;
    logic             r_hdr_valid;
    udp_tx_hdr_t      r_hdr;
    logic             r_busy;

    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_grant_idx;
    logic               w_any_valid;
    logic [IW-1:0]      w_next_ptr;
    logic               w_beat_done;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req       (req_hdr_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_valid (w_any_valid)
    );

    assign w_next_ptr  = (int'(r_grant_id) >= NUM_REQ - 1) ? {IW{1'b0}} : r_grant_id + IW'(1);
    assign w_beat_done = m_tvalid & m_tready & m_tlast;

    // Datagram sequencing: header capture, header handshake, payload ownership.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_hdr_valid <= 1'b0;
            r_hdr       <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_hdr       <= build_hdr(req_hdr[w_grant_idx], cfg_local_mac, cfg_local_ip);
                        r_grant_id  <= w_grant_idx;
                        r_hdr_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (udp_hdr_ready) begin
                        r_hdr_valid <= 1'b0;
                        r_state     <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_beat_done) begin
                        r_rr_ptr <= w_next_ptr;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_hdr_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake steering; gated by reset so a mid-datagram reset drops everything at once.
    always_comb begin
        req_hdr_ready = '0;
        req_tready    = '0;
        m_tdata       = '0;
        m_tvalid      = 1'b0;
        m_tlast       = 1'b0;
        if (reset) begin
            m_tvalid = 1'b0;
        end else if (r_state == ST_IDLE) begin
            req_hdr_ready = w_grant;
        end else if (r_state == ST_PAYLOAD) begin
            m_tdata                = req_tdata[r_grant_id];
            m_tvalid               = req_tvalid[r_grant_id];
            m_tlast                = req_tlast[r_grant_id];
            req_tready[r_grant_id] = m_tready;
        end else begin
            m_tvalid = 1'b0;
        end
    end

    assign udp_hdr_valid = r_hdr_valid;
    assign udp_hdr       = r_hdr;
    assign grant_id      = r_grant_id;
    assign busy          = r_busy;

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares one UDP TX stack header channel and payload stream between NUM_REQ requesters (e.g. telemetry, command-reply, debug).
- Round-robin arbitration per datagram: the grant covers one header handshake plus all payload beats up to tlast.
- Fills the local MAC/IP source fields from configuration ports and registers the outgoing header.
- Sits between the application sources and the UDP stack's header Input side.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
DATA_WIDTH, 8, payload tdata width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cfg_local_mac  input  48  written to eth_src_mac of every header
cfg_local_ip  input  32  written to ip_source_ip of every header
req_hdr_valid  input  NUM_REQ  per-requester header valid
req_hdr_ready  output  NUM_REQ  per-requester header accept
req_hdr  input  NUM_REQ x udp_tx_req_t  per-requester header fields (pkg)
req_tdata  input  NUM_REQ x DATA_WIDTH  payload data
req_tvalid  input  NUM_REQ  payload valid
req_tready  output  NUM_REQ  payload ready
req_tlast  input  NUM_REQ  payload last beat
udp_hdr_valid  output  1  header valid to stack
udp_hdr_ready  input  1  stack header ready
udp_hdr  output  udp_tx_hdr_t  full header: dest/src MAC, eth_type, dscp, ecn, ttl, src/dest IP, ports, length, checksum
m_tdata  output  DATA_WIDTH  payload to stack
m_tvalid  output  1  payload valid
m_tready  input  1  payload ready
m_tlast  output  1  payload last
grant_id  output  $clog2(NUM_REQ) (min 1)  index of current owner
busy  output  1  high in HDR or PAYLOAD

Behaviour:
- Reset (async, active-high): state=IDLE; rr_ptr=0; grant_id=0; udp_hdr_valid=0; udp_hdr=0; req_hdr_ready=0; req_tready=0; m_tvalid=0; m_tlast=0; m_tdata=0; busy=0.
- FSM IDLE -> HDR -> PAYLOAD -> IDLE.
- IDLE:
  - Winner g = first index with req_hdr_valid set, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_hdr_ready[g]=1 combinationally in that same cycle; no other bit is set.
  - On that clock edge: capture req_hdr[g] into udp_hdr, forcing eth_src_mac=cfg_local_mac, ip_source_ip=cfg_local_ip, eth_type=0x0800.
  - On the same edge: grant_id<=g, udp_hdr_valid<=1, state<=HDR.
  - Latency: request-to-udp_hdr_valid is 1 cycle.
- HDR:
  - udp_hdr is held stable while udp_hdr_valid=1.
  - On udp_hdr_ready=1: udp_hdr_valid<=0, state<=PAYLOAD.
  - All req_hdr_ready stay 0.
- PAYLOAD:
  - Combinational mux: m_tdata/m_tvalid/m_tlast = req_*[grant_id]; req_tready[grant_id]=m_tready; other req_tready=0.
  - On m_tvalid & m_tready & m_tlast: state<=IDLE, rr_ptr<=(grant_id+1) mod NUM_REQ.
- Outside PAYLOAD: m_tvalid=0, m_tlast=0, m_tdata=0, all req_tready=0.
- A requester's payload beats presented before its grant are ignored and stalled (tready=0).
- Non-owner headers wait; the owner may present its next header during PAYLOAD but is not accepted until IDLE.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0.
- NUM_REQ=1: rr_ptr is constant 0; behaviour is otherwise identical.
- Zero-length payload is unsupported; the requester must send at least one beat with tlast.
- Reset mid-datagram: immediate return to IDLE; the downstream frame is truncated, and the stack is reset by the same reset.
- No timeout.
- cfg_* are sampled only at the header-capture edge.

Decomposition:
- Package udp_tx_pkg:
  - udp_tx_req_t: dest MAC, dscp, ecn, ttl, dest IP, src/dest port, udp_length, udp_checksum.
  - udp_tx_hdr_t: full header.
  - ETH_TYPE_IPV4=16'h0800.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and rr_ptr; outputs one-hot grant, index, any_valid. Purely combinational and reusable.

Test Plan:
- Single request: req 2 header (dest_port=0x1234) plus 3 payload beats, stack always ready -> req_hdr_ready[2] pulses 1 cycle; udp_hdr_valid the next cycle with src MAC/IP = cfg and eth_type=0x0800; m_* carries 3 beats with tlast on beat 3; rr_ptr=3.
- All 4 continuously valid, 2-beat payloads -> grant order 0,1,2,3,0; no beat reaches the wrong requester; non-owner tready is 0 throughout.
- Header backpressure: udp_hdr_ready low 5 cycles -> udp_hdr_valid and udp_hdr held stable; no payload beat passes until the handshake.
- Payload backpressure: m_tready toggling 1010 -> req_tready[grant] mirrors it; every beat is transferred exactly once; state returns to IDLE only on the tlast handshake.
- Reset asserted mid-PAYLOAD (beat 2 of 4) -> same-cycle async clear of all outputs; after release, a new request from req 1 is granted with rr_ptr=0 semantics.
- Early payload: req 3 drives tvalid before its grant -> req_tready[3]=0 until its header is accepted and it owns PAYLOAD.
